// File: rtl/vga_board_decoder.sv
// vga_board_decoder
//   Receive-side companion to the Game of Life VGA generator. Recovers pixel
//   and line position from the sync edges and samples the centre pixel of
//   each of the 64 board cells. It rebuilds the 8x8 board as one 64-bit word
//   per clean frame.
//
// Ports
//   clk         pixel clock (same clock as the generator)
//   rst_n       asynchronous, active-low reset
//   vga_in      {hsync, B0, G0, R0, vsync, B1, G1, R1}; both syncs active low
//   board       last committed board; bit r*8+c = row r, column c (1 = alive)
//   frame_valid one-cycle pulse when board updates
//   frame_err   one-cycle pulse when a locked frame is rejected (bad colour)
//   locked      high while the FSM is in LOCKED
//   frame_cnt   accepted-frame counter; wraps
//   still_cnt   consecutive identical accepted frames (0 unless enabled)
//
// Build option
//   VGA_DEC_STILL_EN : enables still_cnt. When the macro is undefined,
//                      still_cnt is tied to 0.
`timescale 1ns/1ps
module vga_board_decoder #(
  parameter int H_VISIBLE    = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int CELL_SIZE    = 50,
  parameter int BOARD_X0     = 120,
  parameter int BOARD_Y0     = 40,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic [63:0] board,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [7:0]  still_cnt
);

  // 4:3 timing: the visible line count follows from the visible width.
  // The commit happens as the line counter wraps into this line.
  localparam int V_VISIBLE = (H_VISIBLE * 3) / 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNCING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  good, good_nx;
  logic        mis_seen, mis_seen_nx;

  logic [7:0]  vga_r;
  logic        hs_prev, vs_prev;
  logic        hs_edge, vs_edge, h_mis, v_mis, mis_now, h_wrap;
  logic [9:0]  h_cnt, v_cnt;

  logic        col_hit, row_hit;
  logic [2:0]  col_idx, row_idx;
  logic [1:0]  col_r, col_g, col_b;
  logic        is_alive, is_dead, lock_ok;
  logic [63:0] shadow;
  logic        err_flag, armed;

  // Input stage: all decoding works on the registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r   <= 8'd0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vga_r   <= vga_in;
      hs_prev <= vga_r[7];
      vs_prev <= vga_r[3];
    end
  end

  assign hs_edge = hs_prev & ~vga_r[7];
  assign vs_edge = vs_prev & ~vga_r[3];
  assign h_mis   = hs_edge && (h_cnt != 10'(H_SYNC_START));
  assign v_mis   = vs_edge && (v_cnt != 10'(V_SYNC_START));
  assign mis_now = h_mis | v_mis;
  assign h_wrap  = !hs_edge && (h_cnt == 10'(H_TOTAL - 1));

  // h_cnt describes the registered pixel. The hsync edge pixel is itself
  // H_SYNC_START, so the counter moves on to the following pixel index.
  // v_cnt loads on the vsync edge, and the load wins over the line increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else begin
      if (hs_edge)
        h_cnt <= 10'(H_SYNC_START + 1);
      else if (h_cnt == 10'(H_TOTAL - 1))
        h_cnt <= 10'd0;
      else
        h_cnt <= h_cnt + 10'd1;

      if (vs_edge)
        v_cnt <= 10'(V_SYNC_START);
      else if (h_wrap)
        v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      good     <= 4'd0;
      mis_seen <= 1'b0;
    end else begin
      state    <= state_nx;
      good     <= good_nx;
      mis_seen <= mis_seen_nx;
    end
  end

  // Lock FSM: next state. mis_seen remembers any mismatch since the last
  // vsync edge, so that a frame counts as good only if it was clean throughout.
  always_comb begin
    state_nx    = state;
    good_nx     = good;
    mis_seen_nx = mis_seen | mis_now;
    case (state)
      UNLOCKED: begin
        good_nx     = 4'd0;
        mis_seen_nx = 1'b0;
        if (vs_edge) state_nx = SYNCING;
      end
      SYNCING: begin
        if (vs_edge) begin
          mis_seen_nx = 1'b0;
          if (mis_seen || mis_now) begin
            good_nx = 4'd0;
          end else if (int'(good) + 1 >= LOCK_FRAMES) begin
            good_nx  = 4'd0;
            state_nx = LOCKED;
          end else begin
            good_nx = good + 4'd1;
          end
        end else if (mis_now) begin
          good_nx = 4'd0;
        end
      end
      LOCKED: begin
        mis_seen_nx = 1'b0;
        if (mis_now) state_nx = UNLOCKED;
      end
      default: state_nx = UNLOCKED;
    endcase
  end

  assign locked = (state == LOCKED);

  // Cell-centre match: eight comparators per axis, no division.
  always_comb begin
    col_hit = 1'b0;
    col_idx = 3'd0;
    row_hit = 1'b0;
    row_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (h_cnt == 10'(BOARD_X0 + CELL_SIZE * i + CELL_SIZE / 2)) begin
        col_hit = 1'b1;
        col_idx = 3'(i);
      end
      if (v_cnt == 10'(BOARD_Y0 + CELL_SIZE * i + CELL_SIZE / 2)) begin
        row_hit = 1'b1;
        row_idx = 3'(i);
      end
    end
  end

  assign col_r    = {vga_r[0], vga_r[4]};
  assign col_g    = {vga_r[1], vga_r[5]};
  assign col_b    = {vga_r[2], vga_r[6]};
  assign is_alive = (col_r == 2'b10) && (col_g == 2'b00) && (col_b == 2'b10);
  assign is_dead  = (col_r == 2'b11) && (col_g == 2'b10) && (col_b == 2'b11);
  assign lock_ok  = (state == LOCKED) && !mis_now;

`ifdef VGA_DEC_STILL_EN
  logic [7:0] still_q;
  assign still_cnt = still_q;
`else
  assign still_cnt = 8'd0;
`endif

  // Sampling and commit. armed is set at the start of a frame seen entirely
  // in LOCKED, so a commit is only made from a complete set of 64 samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board       <= 64'd0;
      shadow      <= 64'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
      err_flag    <= 1'b0;
      armed       <= 1'b0;
`ifdef VGA_DEC_STILL_EN
      still_q     <= 8'd0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (!lock_ok) begin
        armed    <= 1'b0;
        err_flag <= 1'b0;
`ifdef VGA_DEC_STILL_EN
        still_q  <= 8'd0;
`endif
      end else begin
        if (h_wrap && v_cnt == 10'(V_TOTAL - 1))
          armed <= 1'b1;
        if (row_hit && col_hit) begin
          if (is_alive)
            shadow[{row_idx, col_idx}] <= 1'b1;
          else if (is_dead)
            shadow[{row_idx, col_idx}] <= 1'b0;
          else
            err_flag <= 1'b1;
        end
        if (h_wrap && v_cnt == 10'(V_VISIBLE - 1)) begin
          err_flag <= 1'b0;
          if (armed) begin
            if (err_flag) begin
              frame_err <= 1'b1;
            end else begin
              board       <= shadow;
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
`ifdef VGA_DEC_STILL_EN
              if (shadow != board)
                still_q <= 8'd0;
              else if (still_q != 8'd255)
                still_q <= still_q + 8'd1;
`endif
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_board_decoder.sv
// Bench for vga_board_decoder. A scaled generator timing (56x40 clocks,
// 4-pixel cells) keeps each frame short. Expected commits are pushed to a
// queue when a frame is started and popped when the DUT pulses.
`timescale 1ns/1ps
module tb_vga_board_decoder;

  localparam int H_VIS = 48;
  localparam int H_TOT = 56;
  localparam int H_SS  = 50;
  localparam int H_SW  = 4;
  localparam int V_TOT = 40;
  localparam int V_SS  = 37;
  localparam int V_SW  = 2;
  localparam int CELL  = 4;
  localparam int X0    = 4;
  localparam int Y0    = 2;
  localparam int LOCKF = 2;
  localparam int V_VIS = (H_VIS * 3) / 4;
  localparam logic [63:0] UW = 64'h5088_8888_0609_0909;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] vga_in;
  logic [63:0] board;
  logic frame_valid, frame_err, locked;
  logic [15:0] frame_cnt;
  logic [7:0] still_cnt;

  always #5 clk = ~clk;

  vga_board_decoder #(
    .H_VISIBLE(H_VIS), .H_TOTAL(H_TOT), .H_SYNC_START(H_SS),
    .V_TOTAL(V_TOT), .V_SYNC_START(V_SS), .CELL_SIZE(CELL),
    .BOARD_X0(X0), .BOARD_Y0(Y0), .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .board(board),
    .frame_valid(frame_valid), .frame_err(frame_err), .locked(locked),
    .frame_cnt(frame_cnt), .still_cnt(still_cnt)
  );

  // scoreboard
  typedef struct packed {
    logic        err;
    logic [63:0] brd;
    logic [15:0] cnt;
    logic [7:0]  still;
  } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] m_cnt   = 16'd0;
  logic [63:0] m_prev  = 64'd0;
  logic [7:0]  m_still = 8'd0;
  logic [63:0] cur_b;
  int glitch_x = -1, glitch_y = -1;
  int bad_x = -1, bad_y = -1;
  int rst_x = -1, rst_y = -1;

  function automatic logic [7:0] pixel(input int x, input int y, input logic [63:0] b);
    logic hs, vs;
    logic [1:0] r, g, bl;
    int c, rr;
    hs = !(x >= H_SS && x < H_SS + H_SW);
    vs = !(y >= V_SS && y < V_SS + V_SW);
    r = 2'b00; g = 2'b00; bl = 2'b00;
    if (x >= X0 && x < X0 + 8 * CELL && y >= Y0 && y < Y0 + 8 * CELL) begin
      c  = (x - X0) / CELL;
      rr = (y - Y0) / CELL;
      if (b[rr * 8 + c]) begin r = 2'b10; g = 2'b00; bl = 2'b10; end
      else               begin r = 2'b11; g = 2'b10; bl = 2'b11; end
    end
    if (x == bad_x && y == bad_y) r = 2'b01;
    if (x == glitch_x && y == glitch_y) hs = 1'b0;
    return {hs, bl[0], g[0], r[0], vs, bl[1], g[1], r[1]};
  endfunction

  // driver tasks
  task automatic push_commit(input logic [63:0] b);
    m_cnt = m_cnt + 16'd1;
`ifdef VGA_DEC_STILL_EN
    if (b == m_prev) m_still = (m_still == 8'd255) ? 8'd255 : m_still + 8'd1;
    else             m_still = 8'd0;
`endif
    m_prev = b;
    exp_q.push_back(exp_t'{1'b0, b, m_cnt, m_still});
  endtask

  task automatic push_err();
    exp_q.push_back(exp_t'{1'b1, m_prev, m_cnt, m_still});
  endtask

  // kind: 0 = no pulse expected, 1 = commit, 2 = rejected frame
  task automatic run_frame(input logic [63:0] b, input int kind);
    exp_t e;
    int rst_hold;
    rst_hold = 0;
    if (kind == 1) push_commit(b);
    else if (kind == 2) push_err();
    for (int y = 0; y < V_TOT; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        vga_in = pixel(x, y, b);
        @(posedge clk);
        #1;
        if (rst_hold > 0) begin
          rst_hold--;
          if (rst_hold == 0) rst_n = 1'b1;
        end
        if (frame_valid || frame_err) begin
          n_total++;
          if (frame_valid && frame_err) begin
            n_bad++;
            $display("FAIL pulse_overlap: valid=%0b err=%0b required not both", frame_valid, frame_err);
          end
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: valid=%0b err=%0b at x=%0d y=%0d", frame_valid, frame_err, x, y);
          end else begin
            e = exp_q.pop_front();
            n_total += 4;
            if (frame_err !== e.err) begin
              n_bad++;
              $display("FAIL pulse_kind: err=%0b required %0b", frame_err, e.err);
            end
            if (board !== e.brd) begin
              n_bad++;
              $display("FAIL board: got %h required %h", board, e.brd);
            end
            if (frame_cnt !== e.cnt) begin
              n_bad++;
              $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, e.cnt);
            end
            if (still_cnt !== e.still) begin
              n_bad++;
              $display("FAIL still_cnt: got %0d required %0d", still_cnt, e.still);
            end
            if (x != 0 || y != V_VIS) begin
              n_bad++;
              $display("FAIL pulse_pos: got x=%0d y=%0d required x=0 y=%0d", x, y, V_VIS);
            end
          end
        end
        if (x == glitch_x + 3 && y == glitch_y) begin
          n_total++;
          if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_unlock: locked=%0b required 0", locked);
          end
        end
        if (x == rst_x && y == rst_y) begin
          rst_n = 1'b0;
          #1;
          n_total++;
          if ({board, frame_valid, frame_err, locked, frame_cnt, still_cnt} !== 91'd0) begin
            n_bad++;
            $display("FAIL async_reset: board=%h fv=%0b fe=%0b lk=%0b cnt=%0d still=%0d required all 0",
                     board, frame_valid, frame_err, locked, frame_cnt, still_cnt);
          end
          rst_hold = 3;
          m_cnt = 16'd0; m_prev = 64'd0; m_still = 8'd0;
        end
      end
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_pulse: %0d expected pulses not seen", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_locked(input logic want, input string tag);
    n_total++;
    if (locked !== want) begin
      n_bad++;
      $display("FAIL %s: locked=%0b required %0b", tag, locked, want);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n  = 1'b0;
    vga_in = 8'h88;
    repeat (3) @(posedge clk);
    #1;
    n_total += 3;
    if (board !== 64'd0 || frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_data: board=%h cnt=%0d required 0", board, frame_cnt);
    end
    if (frame_valid !== 1'b0 || frame_err !== 1'b0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: fv=%0b fe=%0b lk=%0b required 0", frame_valid, frame_err, locked);
    end
    if (still_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_still: got %0d required 0", still_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    run_frame(UW, 0);
    run_frame(UW, 0);
    check_locked(1'b0, "lock_after_1_good");
    run_frame(UW, 0);
    check_locked(1'b1, "lock_after_2_good");
  endtask

  task automatic test_decode();
    run_frame(UW, 1);
    n_total += 2;
    if (board !== UW) begin
      n_bad++;
      $display("FAIL decode_board: got %h required %h", board, UW);
    end
    if (frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL decode_cnt: got %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_colour_err();
    bad_x = X0 + 3 * CELL + CELL / 2;
    bad_y = Y0 + 3 * CELL + CELL / 2;
    run_frame(UW, 2);
    bad_x = -1;
    bad_y = -1;
    n_total++;
    if (board !== UW || frame_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL err_hold: board=%h cnt=%0d required %h 1", board, frame_cnt, UW);
    end
    run_frame(UW, 1);
  endtask

  task automatic test_still();
    logic [63:0] b1, b2;
    b1 = {$urandom(), $urandom()};
    if (b1 == UW) b1 = ~b1;
    run_frame(b1, 1);
    for (int i = 0; i < 4; i++) run_frame(b1, 1);
    b2 = b1 ^ {32'd0, ($urandom() | 32'd1)};
    run_frame(b2, 1);
    cur_b = b2;
  endtask

  task automatic test_back_to_back_glitch();
    glitch_x = 20;
    glitch_y = 10;
    m_still  = 8'd0;
    run_frame(cur_b, 0);
    glitch_x = -1;
    glitch_y = -1;
    run_frame(cur_b, 0);
    check_locked(1'b0, "glitch_relock_1");
    run_frame(cur_b, 0);
    check_locked(1'b1, "glitch_relock_2");
    run_frame(cur_b, 1);
  endtask

  task automatic test_reset_mid();
    rst_x = 10;
    rst_y = 10;
    run_frame(cur_b, 0);
    rst_x = -1;
    rst_y = -1;
    run_frame(cur_b, 0);
    check_locked(1'b0, "reset_relock_1");
    run_frame(cur_b, 0);
    check_locked(1'b1, "reset_relock_2");
    run_frame(cur_b, 1);
  endtask

  // report
  initial begin
    cur_b = UW;
    test_reset();
    test_lock();
    test_decode();
    test_colour_err();
    test_still();
    test_back_to_back_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
